// File: rtl/gate_sweep_controller.sv
// Walks the 2-input gate bank through operand combos 00..11, captures a truth table per gate, checks it against golden.
// done pulses 4*(SETTLE_CYCLES+1)+1 cycles after the start edge; start is ignored unless IDLE, so there is no queueing.
module gate_sweep_controller #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [2:0] gate_sel_i,
   output logic       gate_a_o,
   output logic       gate_b_o,
   input  logic [7:0] gate_result_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] truth_table_o,
   output logic [7:0] error_mask_o,
   output logic       error_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_CHECK,
      S_DONE
   } state_t;

   // Entry g is gate g's expected table; bit i is the result for {a,b} = i.
   localparam logic [7:0][3:0] GOLDEN = {
      4'b1100,   // YES (A)
      4'b1001,   // XNOR
      4'b0001,   // NOR
      4'b0111,   // NAND
      4'b0011,   // NOT A
      4'b0110,   // XOR
      4'b1110,   // OR
      4'b1000    // AND
   };

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t          state_q, state_d;
   logic [1:0]      combo_q, combo_d;
   logic [3:0]      wait_q, wait_d;
   logic [7:0][3:0] tbl_q, tbl_d;
   logic [7:0]      mask_q, mask_d;
   logic            err_q, err_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         combo_q <= 2'd0;
         wait_q  <= 4'd0;
         tbl_q   <= '0;
         mask_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         combo_q <= combo_d;
         wait_q  <= wait_d;
         tbl_q   <= tbl_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      combo_d = combo_q;
      wait_d  = wait_q;
      tbl_d   = tbl_q;
      mask_d  = mask_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               combo_d = 2'd0;
               wait_d  = 4'd0;
               mask_d  = 8'h00;
               err_d   = 1'b0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            wait_d = wait_q + 4'd1;
            if (wait_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            // Operands still hold combo_q here, so the bank output matches this column.
            for (int g = 0; g < 8; g++) begin
               tbl_d[g][combo_q] = gate_result_i[g];
            end
            if (combo_q == 2'd3) begin
               state_d = S_CHECK;
            end else begin
               combo_d = combo_q + 2'd1;
               wait_d  = 4'd0;
               state_d = S_SETTLE;
            end
         end
         S_CHECK: begin
            for (int g = 0; g < 8; g++) begin
               mask_d[g] = (tbl_q[g] != GOLDEN[g]);
            end
            err_d   = |mask_d;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Operands are the combo register itself, so they park at 11 after a sweep.
   assign gate_a_o      = combo_q[1];
   assign gate_b_o      = combo_q[0];
   assign busy_o        = (state_q == S_SETTLE) || (state_q == S_SAMPLE) || (state_q == S_CHECK);
   assign done_o        = (state_q == S_DONE);
   assign truth_table_o = tbl_q[gate_sel_i];
   assign error_mask_o  = mask_q;
   assign error_o       = err_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: two instances (SETTLE_CYCLES 1 and 3) driven by a behavioural gate bank with stuck-at faults.
`timescale 1ns/1ps
module tb_gate_sweep_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start1, start3;
   logic [2:0] gate_sel;
   logic [7:0] f1, f0;   // stuck-at-1 / stuck-at-0 masks applied to the bank
   logic       a1, b1, busy1, done1, err1, a3, b3, busy3, done3, err3;
   logic [3:0] tt1, tt3;
   logic [7:0] mask1, mask3, res1, res3;
   logic [3:0] golden [8];
   int         checks = 0;
   int         passed = 0;
   int         fails  = 0;

   always #5 clk = ~clk;

   function automatic logic ideal(input int g, input logic a, input logic b);
      case (g)
         0: return a & b;
         1: return a | b;
         2: return a ^ b;
         3: return ~a;
         4: return ~(a & b);
         5: return ~(a | b);
         6: return ~(a ^ b);
         default: return a;
      endcase
   endfunction

   function automatic logic [7:0] bank(input logic a, input logic b, input logic [7:0] s1, input logic [7:0] s0);
      logic [7:0] v;
      for (int g = 0; g < 8; g++) v[g] = ideal(g, a, b);
      return (v | s1) & ~s0;
   endfunction

   function automatic logic [3:0] exp_tbl(input int g, input logic [7:0] s1, input logic [7:0] s0);
      logic [3:0] t;
      for (int i = 0; i < 4; i++) begin
         t[i] = ideal(g, (i >= 2), (i % 2 == 1));
         if (s1[g]) t[i] = 1'b1;
         if (s0[g]) t[i] = 1'b0;
      end
      return t;
   endfunction

   assign res1 = bank(a1, b1, f1, f0);
   assign res3 = bank(a3, b3, f1, f0);

   gate_sweep_controller #(.SETTLE_CYCLES(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .gate_sel_i(gate_sel),
      .gate_a_o(a1), .gate_b_o(b1), .gate_result_i(res1), .busy_o(busy1),
      .done_o(done1), .truth_table_o(tt1), .error_mask_o(mask1), .error_o(err1)
   );

   gate_sweep_controller #(.SETTLE_CYCLES(3)) dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .gate_sel_i(gate_sel),
      .gate_a_o(a3), .gate_b_o(b3), .gate_result_i(res3), .busy_o(busy3),
      .done_o(done3), .truth_table_o(tt3), .error_mask_o(mask3), .error_o(err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) start1 = v;
      else        start3 = v;
   endtask

   task automatic obs(input int d, output logic [1:0] ab, output logic bz, output logic dn);
      ab = (d == 0) ? {a1, b1} : {a3, b3};
      bz = (d == 0) ? busy1 : busy3;
      dn = (d == 0) ? done1 : done3;
   endtask

   task automatic check_tables(input int d, input string tag, input logic [7:0] s1, input logic [7:0] s0);
      logic [7:0] em;
      logic [3:0] et;
      for (int g = 0; g < 8; g++) begin
         et = exp_tbl(g, s1, s0);
         em[g] = (et != golden[g]);
         gate_sel = 3'(g);
         #1;
         chk($sformatf("%s_tt%0d", tag, g), (d == 0) ? tt1 : tt3, et);
      end
      chk({tag, "_mask"}, (d == 0) ? mask1 : mask3, em);
      chk({tag, "_err"}, (d == 0) ? err1 : err3, |em);
   endtask

   task automatic check_reset(input string tag);
      logic [1:0] ab;
      logic       bz, dn;
      for (int d = 0; d < 2; d++) begin
         obs(d, ab, bz, dn);
         chk($sformatf("%s_ab%0d", tag, d), ab, 2'b00);
         chk($sformatf("%s_busy%0d", tag, d), bz, 1'b0);
         chk($sformatf("%s_done%0d", tag, d), dn, 1'b0);
         chk($sformatf("%s_mask%0d", tag, d), (d == 0) ? mask1 : mask3, 8'h00);
         chk($sformatf("%s_err%0d", tag, d), (d == 0) ? err1 : err3, 1'b0);
      end
      for (int g = 0; g < 8; g++) begin
         gate_sel = 3'(g);
         #1;
         chk($sformatf("%s_tt1_%0d", tag, g), tt1, 4'h0);
      end
   endtask

   // One full sweep with cycle-by-cycle operand/busy/done checks; noisy adds ignored start pulses.
   task automatic sweep(input int d, input int s, input string tag, input logic [7:0] s1, input logic [7:0] s0,
                        input bit noisy);
      int         len;
      logic [1:0] ab;
      logic       bz, dn;
      len = 4 * (s + 1);
      f1 = s1;
      f0 = s0;
      set_start(d, 1'b1);
      step();
      set_start(d, 1'b0);
      for (int k = 0; k <= len + 2; k++) begin
         if (k > 0) step();
         obs(d, ab, bz, dn);
         chk($sformatf("%s_ab_k%0d", tag, k), ab, (k < len) ? 2'(k / (s + 1)) : 2'd3);
         chk($sformatf("%s_busy_k%0d", tag, k), bz, (k <= len));
         chk($sformatf("%s_done_k%0d", tag, k), dn, (k == len + 1));
         if (noisy && k <= len) set_start(d, 1'($urandom_range(0, 1)));
         else if (noisy && k == len + 1) set_start(d, 1'b1);
         else set_start(d, 1'b0);
      end
      check_tables(d, tag, s1, s0);
   endtask

   initial begin
      logic [1:0] ab;
      logic       bz, dn;
      logic [7:0] r1, r0;
      int         dsel;
      golden[0] = 4'b1000; golden[1] = 4'b1110; golden[2] = 4'b0110; golden[3] = 4'b0011;
      golden[4] = 4'b0111; golden[5] = 4'b0001; golden[6] = 4'b1001; golden[7] = 4'b1100;
      f1 = 8'h00;
      f0 = 8'h00;
      gate_sel = 3'd0;
      rst_n  = 1'b0;
      start1 = 1'b1;
      start3 = 1'b1;
      step();
      step();
      check_reset("rst");
      start1 = 1'b0;
      start3 = 1'b0;
      rst_n  = 1'b1;
      step();
      chk("rst_idle_busy1", busy1, 1'b0);
      chk("rst_idle_busy3", busy3, 1'b0);

      sweep(0, 1, "nom", 8'h00, 8'h00, 1'b0);
      sweep(0, 1, "fault", 8'h01, 8'h40, 1'b0);
      chk("fault_mask_const", mask1, 8'h41);
      sweep(0, 1, "extra", 8'h00, 8'h00, 1'b1);

      // start held for 30 sampled edges: sweeps launch every 11 cycles.
      f1 = 8'h00;
      f0 = 8'h00;
      set_start(0, 1'b1);
      for (int k = 0; k <= 40; k++) begin
         step();
         chk($sformatf("held_done_k%0d", k), done1, (k % 11 == 9) && (k <= 31));
         if (k == 29) set_start(0, 1'b0);
      end

      set_start(0, 1'b1);
      step();
      set_start(0, 1'b0);
      for (int k = 1; k <= 4; k++) step();
      obs(0, ab, bz, dn);
      chk("midrst_combo2", ab, 2'b10);
      rst_n = 1'b0;
      step();
      check_reset("midrst");
      rst_n = 1'b1;
      step();
      chk("midrst_no_done", done1, 1'b0);
      sweep(0, 1, "post_rst", 8'h00, 8'h00, 1'b0);

      sweep(1, 3, "s3", 8'h00, 8'h00, 1'b0);

      for (int it = 0; it < 6; it++) begin
         dsel = int'($urandom_range(0, 1));
         r1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         r0 = 8'($urandom) & 8'($urandom);
         sweep(dsel, (dsel == 0) ? 1 : 3, $sformatf("rnd%0d", it), r1, r0, 1'b1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
